// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the dual-fetch front end.
// Contents: fetch_entry_t (pc + instruction pair stored per queue slot),
//           RESET_PC_DEFAULT (default boot address), NOP_INSTR (canonical addi x0,x0,0).
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the instruction-memory bus, redirect input and decode-side outputs.
// Signals: imem_addr/imem_rd1/imem_rd2 (combinational imem read of two words),
//          redirect_valid/redirect_pc (flush and restart), dec_take (decode consumption),
//          inst0_*/inst1_* (two in-order instructions presented to decode).
// Modports: master = fetch unit side, slave = memory/decode environment side.
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd1;
    logic [31:0] imem_rd2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dec_take;
    logic        inst0_valid;
    logic [31:0] inst0;
    logic [31:0] inst0_pc;
    logic        inst1_valid;
    logic [31:0] inst1;
    logic [31:0] inst1_pc;
    modport master (
        output imem_addr, inst0_valid, inst0, inst0_pc, inst1_valid, inst1, inst1_pc,
        input  imem_rd1, imem_rd2, redirect_valid, redirect_pc, dec_take
    );
    modport slave (
        input  imem_addr, inst0_valid, inst0, inst0_pc, inst1_valid, inst1, inst1_pc,
        output imem_rd1, imem_rd2, redirect_valid, redirect_pc, dec_take
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer with two write ports and two read ports of fetch_entry_t.
// Ports: clk, rst_n (async active-low), push (write wdata0/wdata1 at tail/tail+1),
//        take (requested pops, 3 acts as 2), flush (empty the queue),
//        count (occupancy), rdata0/rdata1 (entries at head/head+1, unmasked).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 8,
    localparam int PW = $clog2(FQ_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wdata0,
    input  fetch_entry_t wdata1,
    input  logic [1:0]   take,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t rdata0,
    output fetch_entry_t rdata1
);
    fetch_entry_t mem [FQ_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] take_c, eff;
    // Pops are clamped to occupancy so the queue can never underflow.
    always_comb begin
        take_c = take[1] ? CW'(2) : CW'(take);
        eff = (count < take_c) ? count : take_c;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + eff[PW-1:0];
            tail  <= push ? tail + PW'(2) : tail;
            count <= count + (push ? CW'(2) : CW'(0)) - eff;
        end
    end
    // Storage is deliberately not reset; valid gating downstream hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail]          <= wdata0;
            mem[tail + PW'(1)] <= wdata1;
        end
    end
    assign rdata0 = mem[head];
    assign rdata1 = mem[head + PW'(1)];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: dual-fetch front end owning the PC, feeding a fetch queue, presenting two instructions.
// Ports: clk, rst_n (async active-low), bus (fetch_if.master: imem bus, redirect, decode side).
// Parameters: RESET_PC (boot address, 8-byte aligned), FQ_DEPTH (queue entries, power of two >= 4).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FQ_DEPTH = 8,
    localparam int CW = $clog2(FQ_DEPTH) + 1
) (
    input logic    clk,
    input logic    rst_n,
    fetch_if.master bus
);
    logic [31:0]  pc;
    logic [CW-1:0] count;
    logic         push;
    logic [1:0]   take;
    fetch_entry_t wdata0, wdata1, rdata0, rdata1;
    // Free space uses start-of-cycle occupancy; a redirect suppresses both push and pop.
    always_comb begin
        push   = !bus.redirect_valid && (count <= CW'(FQ_DEPTH - 2));
        take   = bus.redirect_valid ? 2'd0 : bus.dec_take;
        wdata0 = '{pc: pc, instr: bus.imem_rd1};
        wdata1 = '{pc: pc + 32'd4, instr: bus.imem_rd2};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (bus.redirect_valid)
            pc <= bus.redirect_pc & ~32'h3;
        else if (push)
            pc <= pc + 32'd8;
    end
    fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .take   (take),
        .flush  (bus.redirect_valid),
        .count  (count),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );
    always_comb begin
        bus.imem_addr   = pc;
        bus.inst0_valid = count != '0;
        bus.inst1_valid = count >= CW'(2);
        bus.inst0       = bus.inst0_valid ? rdata0.instr : '0;
        bus.inst0_pc    = bus.inst0_valid ? rdata0.pc : '0;
        bus.inst1       = bus.inst1_valid ? rdata1.instr : '0;
        bus.inst1_pc    = bus.inst1_valid ? rdata1.pc : '0;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;
    localparam int FQ_DEPTH = 8;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] sb[$];
    logic [31:0] mpc;
    fetch_if bus ();
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction
    assign bus.imem_rd1 = mem_word(bus.imem_addr);
    assign bus.imem_rd2 = mem_word(bus.imem_addr + 32'd4);
    fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %h expected %h", tag, got, exp);
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_addr"}, bus.imem_addr, RESET_PC);
        check({tag, "_v0"}, 32'(bus.inst0_valid), 32'd0);
        check({tag, "_v1"}, 32'(bus.inst1_valid), 32'd0);
        check({tag, "_pc0"}, bus.inst0_pc, 32'd0);
        check({tag, "_i0"}, bus.inst0, 32'd0);
        check({tag, "_pc1"}, bus.inst1_pc, 32'd0);
    endtask
    // Called at a falling edge: checks current outputs against the scoreboard,
    // drives this cycle's inputs, advances the model, then moves to the next falling edge.
    task automatic step(input logic [1:0] take, input logic redir, input logic [31:0] rpc);
        int sz, tk, eff;
        logic [31:0] p0, p1;
        sz = sb.size();
        p0 = '0;
        p1 = '0;
        if (sz >= 1) p0 = sb[0];
        if (sz >= 2) p1 = sb[1];
        check("addr", bus.imem_addr, mpc);
        check("v0", 32'(bus.inst0_valid), 32'(sz >= 1));
        check("v1", 32'(bus.inst1_valid), 32'(sz >= 2));
        check("pc0", bus.inst0_pc, p0);
        check("i0", bus.inst0, sz >= 1 ? mem_word(p0) : 32'd0);
        check("pc1", bus.inst1_pc, p1);
        check("i1", bus.inst1, sz >= 2 ? mem_word(p1) : 32'd0);
        bus.dec_take = take;
        bus.redirect_valid = redir;
        bus.redirect_pc = rpc;
        if (redir) begin
            sb.delete();
            mpc = rpc & ~32'h3;
        end else begin
            tk = (take == 2'd3) ? 2 : int'(take);
            eff = (tk < sz) ? tk : sz;
            repeat (eff) void'(sb.pop_front());
            if (FQ_DEPTH - sz >= 2) begin
                sb.push_back(mpc);
                sb.push_back(mpc + 32'd4);
                mpc = mpc + 32'd8;
            end
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.dec_take = 2'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        sb.delete();
        mpc = RESET_PC;
    endtask
    initial begin
        bus.dec_take = 2'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        mpc = RESET_PC;
        do_reset();
        repeat (6) step(2'd0, 1'b0, 32'd0);
        check("full_addr", bus.imem_addr, 32'h8000_0020);
        check("full_v1", 32'(bus.inst1_valid), 32'd1);
        check("full_pc0", bus.inst0_pc, 32'h8000_0000);
        do_reset();
        repeat (10) step(2'd2, 1'b0, 32'd0);
        repeat (3) step(2'd3, 1'b0, 32'd0);
        step(2'd2, 1'b1, 32'h8000_0103);
        check("redir_addr", bus.imem_addr, 32'h8000_0100);
        check("redir_v0", 32'(bus.inst0_valid), 32'd0);
        step(2'd2, 1'b0, 32'd0);
        check("redir_pc0", bus.inst0_pc, 32'h8000_0100);
        for (int i = 0; i < 20; i++)
            step((i % 2) ? 2'd2 : 2'd1, 1'b0, 32'd0);
        repeat (4) step(2'd0, 1'b0, 32'd0);
        repeat (3) step(2'd1, 1'b0, 32'd0);
        repeat (6) step(2'd0, 1'b0, 32'd0);
        check("pre_rst_v1", 32'(bus.inst1_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle("async");
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        mpc = RESET_PC;
        repeat (6) step(2'd1, 1'b0, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
